l_modu_key_debounce: RTL and testbench
======================================

# l_modu_key_debounce

Multi-key debouncer and press-event generator driven by the 1 ms square wave from the millisecond clock divider stage. It samples up to KEY_W raw push-button inputs once per millisecond and filters contact bounce over DEB_MS consecutive samples. It emits clean level, press, release and long-press signals per key to downstream control logic such as mode selection and counter start/stop.

## Interface
- KEY_W, 4, number of independent keys
- DEB_MS, 20, consecutive 1 ms samples required to accept a press or release (legal 1..255)
- LONG_MS, 1000, held duration in ms, counted from press acceptance, that fires KEY_LONG (legal 1..65535)
- KEY_ACT_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed

Ports:
- CLK  input  1  system clock (50 MHz in the target design)
- RST  input  1  asynchronous, active-high reset
- CLK1MS  input  1  1 ms period, 50 % duty square wave from the divider; same clock domain, registered
- KEY_IN  input  KEY_W  raw asynchronous key pins
- TICK_1MS  output  1  one-CLK pulse per CLK1MS rising edge
- KEY_LEVEL  output  KEY_W  debounced pressed state, 1 = pressed
- KEY_PRESS  output  KEY_W  one-CLK pulse on accepted press
- KEY_RELEASE  output  KEY_W  one-CLK pulse on accepted release
- KEY_LONG  output  KEY_W  one-CLK pulse, at most once per press, when hold reaches LONG_MS

## Operation
- **Input synchronisation:** two-flop synchroniser per KEY_IN bit. Polarity is then normalised to `pressed = 1` using KEY_ACT_LOW.
- **Tick generation:** a register holds the previous CLK1MS value and resets to 1. `TICK_1MS = CLK1MS & ~prev`. No tick occurs until a genuine 0→1 transition is seen after reset.
- **Per-key state machine:** IDLE, PDEB, HELD, RDEB. State changes and counter updates happen only on tick cycles. `p` is the normalised synchronised sample in the tick cycle.
  - IDLE: if p=1, go to PDEB with deb_cnt=1.
  - PDEB: if p=0, go to IDLE with deb_cnt=0. If p=1, deb_cnt+1. When the incremented value equals DEB_MS, go to HELD, pulse KEY_PRESS, and clear deb_cnt and hold_cnt.
  - HELD: if p=1, hold_cnt increments, saturating at LONG_MS. KEY_LONG pulses on the tick where hold_cnt becomes LONG_MS. If p=0, go to RDEB with deb_cnt=1; hold_cnt is frozen.
  - RDEB: if p=1, return to HELD with deb_cnt=0; hold_cnt resumes from its frozen value with no new KEY_PRESS. If p=0, deb_cnt+1. When it equals DEB_MS, go to IDLE, pulse KEY_RELEASE, and clear hold_cnt.
  - With DEB_MS=1, PDEB and RDEB are entered and completed on the same tick: IDLE→HELD and HELD→IDLE directly.
- **KEY_LEVEL** is 1 in HELD and RDEB, 0 in IDLE and PDEB.
- **Counter widths:** deb_cnt is 8 bits; hold_cnt is 16 bits. Neither wraps: deb_cnt never exceeds DEB_MS and hold_cnt saturates.
- **Independence:** keys are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- **Reset state:** all keys IDLE, counters 0, synchronisers at the released level (KEY_ACT_LOW ? 1 : 0), prev CLK1MS = 1. All outputs are 0 during and immediately after reset.
- **Reset mid-operation:** any in-flight debounce or hold is discarded. No RELEASE pulse is generated for a key that was HELD.

## Timing
- TICK_1MS is combinational from registered CLK1MS and registered prev. It is high in the first CLK cycle where CLK1MS=1 after a 0.
- KEY_PRESS, KEY_RELEASE, KEY_LONG and KEY_LEVEL are registered. They assert in the cycle after the deciding tick cycle. Pulses are exactly 1 CLK wide.
- **Press latency:** from a stable KEY_IN change, 2 CLK (sync) + wait to next tick (≤1 ms) + (DEB_MS−1) further ticks + 1 CLK.
- KEY_LEVEL rises in the same cycle as KEY_PRESS and falls in the same cycle as KEY_RELEASE.
- **Long-press timing:** KEY_LONG fires LONG_MS ticks after the press-acceptance tick, excluding ticks spent in RDEB.
- A KEY_IN change between ticks is invisible unless it persists to the sampling tick. This is intended; there is no glitch capture.

## Test plan
The bench drives CLK1MS directly, toggling every 4 CLK (tick every 8 CLK), with DEB_MS=3, LONG_MS=10, KEY_ACT_LOW=1.
- **Clean press:** KEY_IN[0] 1→0 held → KEY_PRESS[0] single pulse after the 3rd sampled-low tick. KEY_LEVEL[0]=1 from that cycle. Other bits stay 0.
- **Bounce rejection:** KEY_IN[1] low for 2 ticks, high for 1, low for 3 → exactly one KEY_PRESS[1], at the end of the final 3-tick run.
- **Long press:** hold KEY_IN[2] low for 15 ticks after acceptance → one KEY_LONG[2] at the 10th tick after the press pulse and no second pulse. Release for 3 ticks → KEY_RELEASE[2] and KEY_LEVEL[2]=0.
- **Release bounce:** while HELD, KEY_IN[3] high 2 ticks then low again → no KEY_RELEASE and no new KEY_PRESS. KEY_LEVEL[3] stays 1.
- **Simultaneous keys:** KEY_IN[0] and KEY_IN[3] go low on the same cycle → KEY_PRESS=4'b1001 in one cycle.
- **Reset:** assert RST while key 0 is HELD, with CLK1MS=1 at deassert → all outputs 0, no TICK_1MS until the next 0→1 of CLK1MS, no KEY_RELEASE. With the key still low, KEY_PRESS[0] follows after 3 ticks.

Source files
------------

// File: rtl/l_modu_key_debounce.sv
// l_modu_key_debounce: multi-key debouncer sampling on the 1 ms tick, producing level,
// press, release and long-press pulses per key.
module l_modu_key_debounce #(
    parameter int KEY_W       = 4,
    parameter int DEB_MS      = 20,
    parameter int LONG_MS     = 1000,
    parameter int KEY_ACT_LOW = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLK1MS,
    input  logic [KEY_W-1:0] KEY_IN,
    output logic             TICK_1MS,
    output logic [KEY_W-1:0] KEY_LEVEL,
    output logic [KEY_W-1:0] KEY_PRESS,
    output logic [KEY_W-1:0] KEY_RELEASE,
    output logic [KEY_W-1:0] KEY_LONG
);
    localparam logic [KEY_W-1:0] REL_LVL = (KEY_ACT_LOW != 0) ? '1 : '0;
    localparam logic [7:0]       DEB     = 8'(DEB_MS);
    localparam logic [15:0]      LNG     = 16'(LONG_MS);

    typedef enum logic [1:0] {IDLE, PDEB, HELD, RDEB} state_t;

    logic [KEY_W-1:0] sync1, sync2, pressed;
    logic             prev;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= REL_LVL;
            sync2 <= REL_LVL;
            prev  <= 1'b1;
        end else begin
            sync1 <= KEY_IN;
            sync2 <= sync1;
            prev  <= CLK1MS;
        end
    end

    // prev resets high so a CLK1MS already high at reset release is not a tick
    assign TICK_1MS = CLK1MS & ~prev;
    assign pressed  = (KEY_ACT_LOW != 0) ? ~sync2 : sync2;

    genvar k;
    generate
        for (k = 0; k < KEY_W; k++) begin : g_key
            state_t      state;
            logic [7:0]  deb_cnt;
            logic [15:0] hold_cnt;
            logic        p, level_r, press_r, release_r, long_r;
            assign p = pressed[k];
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    state     <= IDLE;
                    deb_cnt   <= '0;
                    hold_cnt  <= '0;
                    level_r   <= 1'b0;
                    press_r   <= 1'b0;
                    release_r <= 1'b0;
                    long_r    <= 1'b0;
                end else begin
                    press_r   <= 1'b0;
                    release_r <= 1'b0;
                    long_r    <= 1'b0;
                    if (TICK_1MS) begin
                        case (state)
                            IDLE: if (p) begin
                                if (DEB == 8'd1) begin
                                    state    <= HELD;
                                    deb_cnt  <= '0;
                                    hold_cnt <= '0;
                                    press_r  <= 1'b1;
                                    level_r  <= 1'b1;
                                end else begin
                                    state   <= PDEB;
                                    deb_cnt <= 8'd1;
                                end
                            end
                            PDEB: if (!p) begin
                                state   <= IDLE;
                                deb_cnt <= '0;
                            end else if (deb_cnt + 8'd1 == DEB) begin
                                state    <= HELD;
                                deb_cnt  <= '0;
                                hold_cnt <= '0;
                                press_r  <= 1'b1;
                                level_r  <= 1'b1;
                            end else begin
                                deb_cnt <= deb_cnt + 8'd1;
                            end
                            HELD: if (p) begin
                                if (hold_cnt != LNG) begin
                                    hold_cnt <= hold_cnt + 16'd1;
                                    long_r   <= (hold_cnt + 16'd1 == LNG);
                                end
                            end else if (DEB == 8'd1) begin
                                state     <= IDLE;
                                deb_cnt   <= '0;
                                hold_cnt  <= '0;
                                release_r <= 1'b1;
                                level_r   <= 1'b0;
                            end else begin
                                state   <= RDEB;
                                deb_cnt <= 8'd1;
                            end
                            RDEB: if (p) begin
                                state   <= HELD;
                                deb_cnt <= '0;
                            end else if (deb_cnt + 8'd1 == DEB) begin
                                state     <= IDLE;
                                deb_cnt   <= '0;
                                hold_cnt  <= '0;
                                release_r <= 1'b1;
                                level_r   <= 1'b0;
                            end else begin
                                deb_cnt <= deb_cnt + 8'd1;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            end
            assign KEY_LEVEL[k]   = level_r;
            assign KEY_PRESS[k]   = press_r;
            assign KEY_RELEASE[k] = release_r;
            assign KEY_LONG[k]    = long_r;
        end
    endgenerate
endmodule

// File: tb/tb_l_modu_key_debounce.sv
// tb_l_modu_key_debounce: scoreboard bench; expected events carry the tick number
// on which each pulse must be decided.
module tb_l_modu_key_debounce;
    logic       clk = 1'b0, rst = 1'b0, c1ms = 1'b0;
    logic [3:0] key = 4'b1111;
    logic       tick;
    logic [3:0] level, press, release_p, long_p;
    int         tick_no = 0, vectors = 0, miscompares = 0, t;
    logic [27:0] q[$];

    l_modu_key_debounce #(.KEY_W(4), .DEB_MS(3), .LONG_MS(10), .KEY_ACT_LOW(1)) dut (
        .CLK(clk), .RST(rst), .CLK1MS(c1ms), .KEY_IN(key), .TICK_1MS(tick),
        .KEY_LEVEL(level), .KEY_PRESS(press), .KEY_RELEASE(release_p), .KEY_LONG(long_p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [27:0] ev(input int tk, input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
        return {16'(tk), pr, rl, lg};
    endfunction

    // returns 2 ns after the DUT's n-th upcoming tick edge
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int t0;
            t0 = tick_no;
            wait (tick_no != t0);
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        forever begin
            repeat (4) @(negedge clk);
            c1ms = ~c1ms;
            if (c1ms) begin
                tick_no++;
                #1 if (!rst) chk("tick_hi", tick, 1);
                @(posedge clk);
                #1 if (!rst) chk("tick_lo", tick, 0);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && (|press || |release_p || |long_p))
            chk("event", {16'(tick_no), press, release_p, long_p}, (q.size() != 0) ? q.pop_front() : '1);
    end

    initial begin
        #1 rst = 1'b1;
        #1 chk("rst_out", {level, press, release_p, long_p}, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        wait_ticks(2);
        // clean press and release on key 0
        t = tick_no; key[0] = 1'b0;
        q.push_back(ev(t + 3, 4'b0001, 0, 0));
        q.push_back(ev(t + 6, 0, 4'b0001, 0));
        wait_ticks(2); chk("pdeb_level", level, 0);
        wait_ticks(1); chk("press_level", level, 4'b0001);
        key[0] = 1'b1;
        wait_ticks(3); chk("rel_level", level, 0);
        wait_ticks(1);
        // bounce on key 1: low 2, high 1, low 3
        t = tick_no; key[1] = 1'b0;
        q.push_back(ev(t + 6, 4'b0010, 0, 0));
        q.push_back(ev(t + 9, 0, 4'b0010, 0));
        wait_ticks(2); key[1] = 1'b1;
        wait_ticks(1); key[1] = 1'b0; chk("bounce_level", level, 0);
        wait_ticks(3); chk("bounce_press_level", level, 4'b0010);
        key[1] = 1'b1;
        wait_ticks(4);
        // long press on key 2
        t = tick_no; key[2] = 1'b0;
        q.push_back(ev(t + 3, 4'b0100, 0, 0));
        q.push_back(ev(t + 13, 0, 0, 4'b0100));
        q.push_back(ev(t + 21, 0, 4'b0100, 0));
        wait_ticks(18); chk("long_level", level, 4'b0100);
        key[2] = 1'b1;
        wait_ticks(3); chk("long_rel_level", level, 0);
        wait_ticks(1);
        // release bounce on key 3
        t = tick_no; key[3] = 1'b0;
        q.push_back(ev(t + 3, 4'b1000, 0, 0));
        q.push_back(ev(t + 9, 0, 4'b1000, 0));
        wait_ticks(3); key[3] = 1'b1;
        wait_ticks(2); key[3] = 1'b0; chk("rdeb_level", level, 4'b1000);
        wait_ticks(1); chk("reheld_level", level, 4'b1000);
        key[3] = 1'b1;
        wait_ticks(3); chk("rdeb_rel_level", level, 0);
        wait_ticks(1);
        // simultaneous press on keys 0 and 3
        t = tick_no; key = 4'b0110;
        q.push_back(ev(t + 3, 4'b1001, 0, 0));
        q.push_back(ev(t + 6, 0, 4'b1000, 0));
        wait_ticks(3); chk("simul_level", level, 4'b1001);
        key[3] = 1'b1;
        wait_ticks(3); chk("simul_rel_level", level, 4'b0001);
        // reset while key 0 is held, CLK1MS high at release
        rst = 1'b1;
        #1 chk("midrst_out", {level, press, release_p, long_p}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("no_tick", tick, 0);
        chk("c1ms_high", c1ms, 1);
        @(posedge clk);
        #1 chk("no_tick2", tick, 0);
        chk("postrst_out", {level, press, release_p, long_p}, 0);
        t = tick_no; 
        q.push_back(ev(t + 3, 4'b0001, 0, 0));
        q.push_back(ev(t + 6, 0, 4'b0001, 0));
        wait_ticks(2); chk("postrst_pdeb", level, 0);
        wait_ticks(1); chk("postrst_level", level, 4'b0001);
        key[0] = 1'b1;
        wait_ticks(3); chk("final_level", level, 0);
        wait_ticks(2);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
